// File: rtl/aemb_dwb_ram_pkg.sv
// Shared definitions for the data-bus RAM responder: FSM state encodings and
// the wait-state counter width.
package aemb_dwb_ram_pkg;

   localparam int CNT_W    = 4;
   localparam int WAIT_MAX = (1 << CNT_W) - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

endpackage

// File: rtl/aemb_dwb_ram_core.sv
// Word-organised RAM with four byte-lane write enables and a registered read
// port; the read register only loads on a read so it holds the last value.
module aemb_dwb_ram_core #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    we,
   input  logic          re,
   input  logic [AW-1:0] adr,
   input  logic [31:0]   wdat,
   output logic [31:0]   rdat
);

   logic [31:0] mem [2**AW];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) mem[adr][8*b +: 8] <= wdat[8*b +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdat <= '0;
      else if (re) rdat <= mem[adr];
   end

endmodule

// File: rtl/aemb_dwb_ram.sv
// Wishbone-classic data-bus responder: RAM with byte-lane writes and a fixed,
// parameterised number of wait states before each one-cycle ack.
module aemb_dwb_ram
   import aemb_dwb_ram_pkg::*;
#(
   parameter int AW   = 10,
   parameter int WAIT = 0
) (
   input  logic          sys_clk_i,
   input  logic          sys_rst_i,
   input  logic          dwb_stb_i,
   input  logic          dwb_wre_i,
   input  logic [3:0]    dwb_sel_i,
   input  logic [AW-1:0] dwb_adr_i,
   input  logic [31:0]   dwb_dat_i,
   output logic [31:0]   dwb_dat_o,
   output logic          dwb_ack_o
);

   generate
      if (WAIT < 0 || WAIT > WAIT_MAX) begin : g_bad_wait
         $error("aemb_dwb_ram: WAIT must be within 0..15");
      end
   endgenerate

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             fire;

   // fire marks the edge that enters ACK; the access is committed there, so
   // an abort or reset before it leaves memory untouched.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fire      = 1'b0;
      case (state)
         S_IDLE: begin
            if (dwb_stb_i) begin
               if (WAIT == 0) begin
                  fire      = 1'b1;
                  state_nxt = S_ACK;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = CNT_W'(WAIT - 1);
               end
            end
         end
         S_WAIT: begin
            if (!dwb_stb_i) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else if (cnt == '0) begin
               fire      = 1'b1;
               state_nxt = S_ACK;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_ACK:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state     <= S_IDLE;
         cnt       <= '0;
         dwb_ack_o <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         dwb_ack_o <= fire;
      end
   end

   aemb_dwb_ram_core #(.AW(AW)) u_core (
      .clk  (sys_clk_i),
      .rst  (sys_rst_i),
      .we   ((fire && dwb_wre_i) ? dwb_sel_i : 4'b0000),
      .re   (fire && !dwb_wre_i),
      .adr  (dwb_adr_i),
      .wdat (dwb_dat_i),
      .rdat (dwb_dat_o)
   );

endmodule

// File: tb/tb_aemb_dwb_ram.sv
// Bench for aemb_dwb_ram: two instances (AW=10/WAIT=0 and AW=4/WAIT=3) checked
// every cycle against a request-counting memory model, plus directed literals.
module tb_aemb_dwb_ram;

   logic        clk = 1'b0;
   logic        rst   [2] = '{1'b1, 1'b1};
   logic        stb   [2] = '{1'b0, 1'b0};
   logic        wre   [2] = '{1'b0, 1'b0};
   logic [3:0]  sel   [2] = '{4'h0, 4'h0};
   logic [9:0]  adr   [2] = '{10'h0, 10'h0};
   logic [31:0] dat   [2] = '{32'h0, 32'h0};
   logic [31:0] dat_o [2];
   logic        ack   [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aemb_dwb_ram #(.AW(10), .WAIT(0)) dut_a (
      .sys_clk_i (clk),      .sys_rst_i (rst[0]),
      .dwb_stb_i (stb[0]),   .dwb_wre_i (wre[0]),
      .dwb_sel_i (sel[0]),   .dwb_adr_i (adr[0]),
      .dwb_dat_i (dat[0]),   .dwb_dat_o (dat_o[0]),
      .dwb_ack_o (ack[0])
   );

   aemb_dwb_ram #(.AW(4), .WAIT(3)) dut_b (
      .sys_clk_i (clk),      .sys_rst_i (rst[1]),
      .dwb_stb_i (stb[1]),   .dwb_wre_i (wre[1]),
      .dwb_sel_i (sel[1]),   .dwb_adr_i (adr[1][3:0]),
      .dwb_dat_i (dat[1]),   .dwb_dat_o (dat_o[1]),
      .dwb_ack_o (ack[1])
   );

   function automatic int wait_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic int mask_of(input int d);
      return (d == 0) ? 1023 : 15;
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %h want %h at %0t", nm, d, got, exp, $time);
      end
   endtask

   // Model: a request completes once stb has been seen high on WAIT+1
   // consecutive edges; the following cycle is the ack and ignores stb.
   bit          m_ack [2];
   logic [31:0] m_dat [2];
   int          run   [2];
   logic [31:0] mmem  [2][1024];

   task automatic step(input int d);
      int a;
      a = int'(adr[d]) & mask_of(d);
      if (m_ack[d]) begin
         m_ack[d] = 1'b0;
         run[d]   = 0;
      end else if (stb[d]) begin
         run[d]++;
         if (run[d] == wait_of(d) + 1) begin
            if (wre[d]) begin
               for (int b = 0; b < 4; b++)
                  if (sel[d][b]) mmem[d][a][8*b +: 8] = dat[d][8*b +: 8];
            end else begin
               m_dat[d] = mmem[d][a];
            end
            m_ack[d] = 1'b1;
            run[d]   = 0;
         end
      end else begin
         run[d] = 0;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
               m_ack[d] = 1'b0;
               m_dat[d] = 32'h0;
               run[d]   = 0;
            end
            chk("model_ack", d, 32'(ack[d]), 32'(m_ack[d]));
            chk("model_dat", d, dat_o[d], m_dat[d]);
            if (!rst[d]) step(d);
         end
      end
   end

   task automatic req(input int d, input bit w, input logic [3:0] s, input logic [9:0] a,
                      input logic [31:0] v, output int lat);
      @(posedge clk); #2;
      wre[d] = w; sel[d] = s; adr[d] = a; dat[d] = v; stb[d] = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!ack[d] && lat < 40);
      if (!ack[d]) chk("ack_timeout", d, 32'(ack[d]), 32'd1);
      #1 stb[d] = 1'b0;
   endtask

   task automatic abort_wr(input int d, input int k, input logic [9:0] a, input logic [31:0] v);
      bit saw;
      @(posedge clk); #2;
      wre[d] = 1'b1; sel[d] = 4'hF; adr[d] = a; dat[d] = v; stb[d] = 1'b1;
      repeat (k) @(posedge clk);
      #2 stb[d] = 1'b0;
      saw = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (ack[d]) saw = 1'b1;
      end
      chk("abort_noack", d, 32'(saw), 32'd0);
   endtask

   initial begin
      int lat, c, c1, c2, nack;
      @(posedge clk); #1;
      chk("rst_ack", 0, 32'(ack[0]), 32'd0);
      chk("rst_dat", 1, dat_o[1], 32'h0);
      @(posedge clk); #2;
      rst[0] = 1'b0; rst[1] = 1'b0;

      // WAIT=0: full write, read, byte lane, empty-select write
      req(0, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF, lat);  chk("w0_lat", 0, lat, 1);
      req(0, 1'b0, 4'hF, 10'd5, 32'h0, lat);         chk("r0_lat", 0, lat, 1);
      chk("full_rd", 0, dat_o[0], 32'hDEADBEEF);
      req(0, 1'b1, 4'b0100, 10'd5, 32'h00AA0000, lat);
      req(0, 1'b0, 4'h0, 10'd5, 32'h0, lat);
      chk("lane_rd", 0, dat_o[0], 32'hDEAABEEF);
      req(0, 1'b1, 4'h0, 10'd5, 32'hFFFFFFFF, lat);  chk("sel0_lat", 0, lat, 1);
      chk("hold_after_wr", 0, dat_o[0], 32'hDEAABEEF);
      req(0, 1'b0, 4'hF, 10'd5, 32'h0, lat);
      chk("sel0_rd", 0, dat_o[0], 32'hDEAABEEF);

      // WAIT=3: latency, abort, aliasing, back-to-back
      req(1, 1'b1, 4'hF, 10'd2, 32'h0BADF00D, lat);  chk("w3_lat", 1, lat, 4);
      req(1, 1'b0, 4'hF, 10'd2, 32'h0, lat);         chk("r3_lat", 1, lat, 4);
      chk("w3_rd", 1, dat_o[1], 32'h0BADF00D);
      abort_wr(1, 2, 10'd2, 32'h55555555);
      req(1, 1'b0, 4'hF, 10'd2, 32'h0, lat);
      chk("abort_rd", 1, dat_o[1], 32'h0BADF00D);
      req(1, 1'b1, 4'hF, 10'd0, 32'hA0A0A0A0, lat);
      req(1, 1'b1, 4'hF, 10'h011, 32'h12345678, lat);
      req(1, 1'b0, 4'hF, 10'd1, 32'h0, lat);
      chk("alias_rd", 1, dat_o[1], 32'h12345678);

      @(posedge clk); #2;
      wre[1] = 1'b0; sel[1] = 4'hF; adr[1] = 10'd0; stb[1] = 1'b1;
      c = 0; c1 = 0; c2 = 0; nack = 0;
      while (nack < 2 && c < 40) begin
         @(posedge clk); #1;
         c++;
         if (ack[1]) begin
            nack++;
            if (nack == 1) begin c1 = c; chk("b2b_rd0", 1, dat_o[1], 32'hA0A0A0A0); adr[1] = 10'd1; end
            else c2 = c;
         end
      end
      #1 stb[1] = 1'b0;
      chk("b2b_gap", 1, c2 - c1, 5);
      chk("b2b_rd1", 1, dat_o[1], 32'h12345678);

      // Reset in the middle of a wait-stated write
      req(1, 1'b0, 4'hF, 10'd2, 32'h0, lat);
      @(posedge clk); #2;
      wre[1] = 1'b1; sel[1] = 4'hF; adr[1] = 10'd2; dat[1] = 32'h11111111; stb[1] = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst[1] = 1'b1;
      #1;
      chk("midrst_ack", 1, 32'(ack[1]), 32'd0);
      chk("midrst_dat", 1, dat_o[1], 32'h0);
      stb[1] = 1'b0;
      @(posedge clk); #2 rst[1] = 1'b0;
      req(1, 1'b0, 4'hF, 10'd2, 32'h0, lat);
      chk("postrst_lat", 1, lat, 4);
      chk("postrst_rd", 1, dat_o[1], 32'h0BADF00D);

      // Randomised traffic over a fully initialised window
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++)
            req(d, 1'b1, 4'hF, 10'(i), $urandom, lat);
      for (int i = 0; i < 160; i++) begin
         int d;
         logic [9:0] a;
         d = int'($urandom_range(0, 1));
         a = (d == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom);
         if (d == 1 && $urandom_range(0, 7) == 0)
            abort_wr(1, int'($urandom_range(1, 3)), a, $urandom);
         else
            req(d, 1'($urandom), 4'($urandom), a, $urandom, lat);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
